zeroriscy_instr_mem_slave: RTL and testbench
============================================

Name: zeroriscy_instr_mem_slave

Overview:
Responder end of the core's instruction-fetch interface: answers `instr_req`/`instr_addr` with `instr_gnt`, `instr_rvalid` and `instr_rdata` from an internal word-addressed instruction RAM. It has a programmable grant delay and a fixed response latency, and supports pipelined requests. A side load port lets the bench or boot logic preload program words. It replaces hand-driven fetch stimulus in core-level simulations.

Parameters:
- ADDR_WIDTH, 10, word-index bits; memory depth is 2**ADDR_WIDTH 32-bit words.
- GNT_DELAY, 0, number of extra cycles `req` is held before `gnt` is given (range 0..7).
- RVALID_DELAY, 1, cycles from the grant edge to `rvalid` (range 1..4).
- INIT_WORD, 32'h0000_0013, value that `rdata` shows before the first response (NOP).

Ports:
- clk_i  in  1  clock; all logic on its rising edge.
- rst_ni  in  1  synchronous active-low reset.
- instr_req_i  in  1  fetch request from the core.
- instr_addr_i  in  32  byte address; bits [1:0] ignored, bits [ADDR_WIDTH+1:2] index the RAM, upper bits ignored (aliasing).
- instr_gnt_o  out  1  request accepted this cycle.
- instr_rvalid_o  out  1  `rdata` valid this cycle.
- instr_rdata_o  out  32  instruction word.
- load_we_i  in  1  load-port write strobe.
- load_addr_i  in  ADDR_WIDTH  load-port word index.
- load_wdata_i  in  32  load-port data.
- proto_err_o  out  1  one-cycle pulse on an interface protocol violation.

Behaviour:
- Reset (synchronous, sampled at the clock edge while `rst_ni`=0):
  - `gnt`=0, `rvalid`=0, `rdata`=INIT_WORD, `proto_err`=0.
  - Grant FSM goes to IDLE, wait counter=0, response pipeline flushed.
  - RAM contents are not reset.
  - Reset mid-transaction drops every in-flight response; no `rvalid` is issued for it after reset releases.
- Grant FSM, states IDLE and WAIT:
  - GNT_DELAY=0: `gnt` = `req` combinationally in IDLE, so the grant lands in the same cycle as `req`. The FSM never leaves IDLE.
  - GNT_DELAY=N>0, IDLE with `req`=1: latch `addr`, counter=1, go to WAIT, `gnt`=0.
  - GNT_DELAY=N>0, WAIT: counter increments each cycle. When counter==N and `req`=1, `gnt`=1 (combinational) and the FSM returns to IDLE at the next edge. The grant therefore arrives in cycle N+1 of `req`.
  - WAIT with `req`=0 (request withdrawn), or `addr` differing from the latched value: pulse `proto_err`, return to IDLE, no grant.
  - Consecutive requests with N>0: each accepted request restarts the count, so there are at least N non-grant cycles between grants.
- Read and response:
  - The RAM is read at the grant edge, using `addr` from the grant cycle.
  - Word and valid flag enter an RVALID_DELAY-deep shift pipeline. `rvalid`=1 with the word exactly RVALID_DELAY cycles after the grant edge.
  - There is no backpressure: the core must always accept responses.
  - Back-to-back grants produce back-to-back `rvalid`s in order.
  - Outstanding responses are bounded by RVALID_DELAY; no FIFO is needed.
  - `rdata` holds the last delivered word while `rvalid`=0.
- Load port:
  - Write takes effect at the clock edge when `load_we`=1.
  - A fetch granted in the same cycle as a write to the same word returns the old word (read-before-write).
  - Loads are allowed while fetches are in flight and are ignored during reset.
- `proto_err` also pulses if `req`=1 while `rst_ni`=0 is released in the same cycle? No. It is asserted only for the WAIT-state violations above.

Test Plan:
- Preload word 0 = 32'h0030_0293 (`addi x5,x0,3`), GNT_DELAY=0, RVALID_DELAY=1. Hold `req`=1 at `addr` 0 for one cycle -> `gnt`=1 in the same cycle; next cycle `rvalid`=1, `rdata`=32'h0030_0293.
- Preload words 0..3 = 32'h11, 32'h22, 32'h33, 32'h44; GNT_DELAY=0, RVALID_DELAY=2. Present `req` on 4 consecutive cycles at `addr` 0, 4, 8, 12 -> 4 consecutive `gnt`s; `rvalid` on cycles 2..5 after the first grant carrying 0x11, 0x22, 0x33, 0x44 in order.
- GNT_DELAY=3. Hold `req` at `addr` 0x8 -> `gnt` on the 4th `req` cycle; `rvalid` one cycle later with word 2. Repeat with `addr` 0x9 -> the same word (bits [1:0] ignored).
- GNT_DELAY=2. Raise `req` for one cycle, then drop it -> `proto_err` pulses one cycle; no `gnt`, no `rvalid`; the FSM is in IDLE.
- In the same cycle, write `load` word 5 = 0xAAAA_AAAA while a fetch at `addr` 0x14 is granted (old value 0x5555_5555) -> response 0x5555_5555; the next fetch at the same address returns 0xAAAA_AAAA.
- Grant a fetch with RVALID_DELAY=3, then assert `rst_ni`=0 one cycle later for two cycles -> no `rvalid` ever appears; `rdata`=0x0000_0013; RAM word unchanged when fetched after reset.

Source files
------------

// File: rtl/zeroriscy_instr_mem_slave.sv
// rtl/zeroriscy_instr_mem_slave.sv - instruction-fetch responder with delayed grant and fixed-latency read
module zeroriscy_instr_mem_slave #(
  parameter int          ADDR_WIDTH   = 10,
  parameter int          GNT_DELAY    = 0,
  parameter int          RVALID_DELAY = 1,
  parameter logic [31:0] INIT_WORD    = 32'h0000_0013
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [31:0]           load_wdata_i,
  output logic                  proto_err_o
);

  localparam int         DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [2:0] GNT_N = 3'(GNT_DELAY);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        gnt, err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    gnt     = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_req_i) begin
          if (GNT_DELAY == 0) begin
            gnt = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'd1;
            addr_d  = instr_addr_i;
          end
        end
      end
      WAIT: begin
        // The full byte address must stay stable while the core waits for its grant.
        if (!instr_req_i || (instr_addr_i != addr_q)) begin
          err     = 1'b1;
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (cnt_q == GNT_N) begin
          gnt     = 1'b1;
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign instr_gnt_o = gnt & rst_ni;
  assign proto_err_o = err & rst_ni;

  logic [31:0]             mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [RVALID_DELAY-1:0] vld_q;
  logic [31:0]             dat_q [RVALID_DELAY];
  logic [31:0]             hold_q;

  assign rd_idx = instr_addr_i[ADDR_WIDTH+1:2];

  always_ff @(posedge clk_i) begin
    if (rst_ni && load_we_i) begin
      mem_q[load_addr_i] <= load_wdata_i;
    end
  end

  // Read happens on the same edge as a possible load, so a colliding fetch sees the old word.
  always_ff @(posedge clk_i) begin
    dat_q[0] <= mem_q[rd_idx];
    for (int i = 1; i < RVALID_DELAY; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      hold_q <= INIT_WORD;
    end else begin
      vld_q[0] <= instr_gnt_o;
      for (int i = 1; i < RVALID_DELAY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      if (vld_q[RVALID_DELAY-1]) begin
        hold_q <= dat_q[RVALID_DELAY-1];
      end
    end
  end

  assign instr_rvalid_o = vld_q[RVALID_DELAY-1];
  assign instr_rdata_o  = vld_q[RVALID_DELAY-1] ? dat_q[RVALID_DELAY-1] : hold_q;

endmodule

// File: tb/tb_zeroriscy_instr_mem_slave.sv
// tb/tb_zeroriscy_instr_mem_slave.sv - model-checked bench over four grant/latency configurations
module tb_zeroriscy_instr_mem_slave;

  localparam int          AW   = 10;
  localparam int          NI   = 4;
  localparam logic [31:0] INIT = 32'h0000_0013;

  function automatic int gd_of(input int k);
    return (k == 2) ? 3 : (k == 3) ? 2 : 0;
  endfunction

  function automatic int rd_of(input int k);
    return (k == 1) ? 2 : (k == 3) ? 3 : 1;
  endfunction

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, req, we;
  logic [31:0]   addr, wd;
  logic [AW-1:0] la;
  logic          gnt_w [NI];
  logic          err_w [NI];
  logic          rv_w  [NI];
  logic [31:0]   rd_w  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    zeroriscy_instr_mem_slave #(
      .ADDR_WIDTH  (AW),
      .GNT_DELAY   (gd_of(g)),
      .RVALID_DELAY(rd_of(g)),
      .INIT_WORD   (INIT)
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .instr_req_i   (req),
      .instr_addr_i  (addr),
      .instr_gnt_o   (gnt_w[g]),
      .instr_rvalid_o(rv_w[g]),
      .instr_rdata_o (rd_w[g]),
      .load_we_i     (we),
      .load_addr_i   (la),
      .load_wdata_i  (wd),
      .proto_err_o   (err_w[g])
    );
  end

  logic [31:0] mem_m  [1024];
  int          run_m  [NI];
  logic [31:0] att_m  [NI];
  logic [31:0] last_m [NI];
  logic        sv_m   [NI][8];
  logic [31:0] sd_m   [NI][8];
  logic        obs_g  [NI];
  logic        obs_e  [NI];
  logic        obs_v  [NI];
  logic [31:0] obs_d  [NI];
  int          cyc, n_cmp, n_bad;
  bit          armed;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
    end
  endtask

  // One clock of stimulus: outputs are compared at the falling edge, then the model advances.
  task automatic step(input logic i_req, input logic [31:0] i_addr, input logic i_we,
                      input logic [AW-1:0] i_la, input logic [31:0] i_wd, input logic i_rn);
    req = i_req; addr = i_addr; we = i_we; la = i_la; wd = i_wd; rst_n = i_rn;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      int          g, r, sl;
      logic        eg, ee, ev;
      logic [31:0] ed;
      g  = gd_of(k);
      r  = rd_of(k);
      sl = cyc % 8;
      ev = sv_m[k][sl];
      ed = ev ? sd_m[k][sl] : last_m[k];
      eg = 1'b0;
      ee = 1'b0;
      if (i_rn) begin
        if (g == 0) eg = i_req;
        else if (run_m[k] > 0) begin
          if (!i_req || (i_addr != att_m[k])) ee = 1'b1;
          else if (run_m[k] == g) eg = 1'b1;
        end
      end
      obs_g[k] = gnt_w[k];
      obs_e[k] = err_w[k];
      obs_v[k] = rv_w[k];
      obs_d[k] = rd_w[k];
      if (armed) begin
        check("gnt", k, {31'd0, gnt_w[k]}, {31'd0, eg});
        check("proto_err", k, {31'd0, err_w[k]}, {31'd0, ee});
        check("rvalid", k, {31'd0, rv_w[k]}, {31'd0, ev});
        check("rdata", k, rd_w[k], ed);
      end
      sv_m[k][sl] = 1'b0;
      if (ev) last_m[k] = ed;
      if (!i_rn) begin
        run_m[k] = 0;
        for (int s = 0; s < 8; s++) sv_m[k][s] = 1'b0;
        last_m[k] = INIT;
      end else begin
        if (eg) begin
          sv_m[k][(cyc + r) % 8] = 1'b1;
          sd_m[k][(cyc + r) % 8] = mem_m[i_addr[AW+1:2]];
        end
        if (g > 0) begin
          if (run_m[k] > 0) begin
            if (ee || eg) run_m[k] = 0;
            else run_m[k]++;
          end else if (i_req) begin
            run_m[k] = 1;
            att_m[k] = i_addr;
          end
        end
      end
    end
    if (i_rn && i_we) mem_m[i_la] = i_wd;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, '0, 32'd0, 1'b1);
  endtask

  logic [31:0] got [$];
  int          cnt_v;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; armed = 1'b0;
    req = 1'b0; addr = '0; we = 1'b0; la = '0; wd = '0; rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      run_m[k] = 0; att_m[k] = '0; last_m[k] = INIT;
      for (int s = 0; s < 8; s++) begin sv_m[k][s] = 1'b0; sd_m[k][s] = '0; end
    end
    @(posedge clk); #1;
    step(1'b0, 32'd0, 1'b0, '0, 32'd0, 1'b0);
    armed = 1'b1;
    step(1'b0, 32'd0, 1'b0, '0, 32'd0, 1'b0);
    check("rst_rdata", 0, obs_d[0], INIT);
    check("rst_rvalid", 3, {31'd0, obs_v[3]}, 32'd0);

    for (int i = 0; i < 1024; i++) step(1'b0, 32'd0, 1'b1, AW'(i), $urandom, 1'b1);

    // Single fetch, then the withdrawn-request protocol error on delayed-grant instances.
    step(1'b0, 32'd0, 1'b1, 10'd0, 32'h0030_0293, 1'b1);
    step(1'b1, 32'd0, 1'b0, '0, 32'd0, 1'b1);
    check("t1_gnt", 0, {31'd0, obs_g[0]}, 32'd1);
    idle();
    check("t1_rvalid", 0, {31'd0, obs_v[0]}, 32'd1);
    check("t1_rdata", 0, obs_d[0], 32'h0030_0293);
    check("t4_err", 3, {31'd0, obs_e[3]}, 32'd1);
    check("t4_nognt", 3, {31'd0, obs_g[3]}, 32'd0);
    idle(); idle(); idle();
    check("t4_norvalid", 3, {31'd0, obs_v[3]}, 32'd0);

    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, AW'(i), 32'(i + 1) * 32'h11, 1'b1);
    got.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(i * 4), 1'b0, '0, 32'd0, 1'b1);
      if (obs_v[1]) got.push_back(obs_d[1]);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      if (obs_v[1]) got.push_back(obs_d[1]);
    end
    check("t2_count", 1, 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("t2_order", 1, got[i], 32'(i + 1) * 32'h11);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h8, 1'b0, '0, 32'd0, 1'b1);
      check("t3_gnt", 2, {31'd0, obs_g[2]}, (i == 3) ? 32'd1 : 32'd0);
    end
    idle();
    check("t3_rvalid", 2, {31'd0, obs_v[2]}, 32'd1);
    check("t3_rdata", 2, obs_d[2], 32'h33);
    idle(); idle();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h9, 1'b0, '0, 32'd0, 1'b1);
    idle();
    check("t3_alias", 2, obs_d[2], 32'h33);
    idle(); idle(); idle();

    step(1'b0, 32'd0, 1'b1, 10'd5, 32'h5555_5555, 1'b1);
    step(1'b1, 32'h14, 1'b1, 10'd5, 32'hAAAA_AAAA, 1'b1);
    check("t5_gnt", 0, {31'd0, obs_g[0]}, 32'd1);
    idle();
    check("t5_old", 0, obs_d[0], 32'h5555_5555);
    step(1'b1, 32'h14, 1'b0, '0, 32'd0, 1'b1);
    idle();
    check("t5_new", 0, obs_d[0], 32'hAAAA_AAAA);
    idle(); idle(); idle(); idle();

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h14, 1'b0, '0, 32'd0, 1'b1);
      check("t6_gnt", 3, {31'd0, obs_g[3]}, (i == 2) ? 32'd1 : 32'd0);
    end
    cnt_v = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 32'd0, 1'b0, '0, 32'd0, 1'b0);
      if (obs_v[3]) cnt_v++;
    end
    for (int i = 0; i < 6; i++) begin
      idle();
      if (obs_v[3]) cnt_v++;
    end
    check("t6_flushed", 3, 32'(cnt_v), 32'd0);
    check("t6_rdata", 3, obs_d[3], INIT);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h14, 1'b0, '0, 32'd0, 1'b1);
    idle(); idle(); idle();
    check("t6_rvalid", 3, {31'd0, obs_v[3]}, 32'd1);
    check("t6_ram", 3, obs_d[3], 32'hAAAA_AAAA);

    while (cyc < 9000) begin
      int          sel, hold, gap;
      logic [9:0]  idx;
      logic [31:0] a;
      sel = $urandom_range(0, 99);
      if (sel < 3) begin
        for (int i = 0; i < $urandom_range(1, 2); i++)
          step(1'b0, $urandom, $urandom_range(0, 1) == 1, AW'($urandom), $urandom, 1'b0);
      end else begin
        idx  = 10'($urandom);
        a    = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0, idx, 2'($urandom)};
        hold = $urandom_range(1, 6);
        for (int h = 0; h < hold; h++) begin
          logic        lw;
          logic [9:0]  lidx;
          if ($urandom_range(0, 9) == 0) a = a ^ 32'h4;
          lw   = ($urandom_range(0, 3) == 0);
          lidx = ($urandom_range(0, 1) == 1) ? a[AW+1:2] : 10'($urandom);
          step(($urandom_range(0, 15) != 0), a, lw, lidx, $urandom, 1'b1);
        end
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++)
          step(1'b0, $urandom, $urandom_range(0, 3) == 0, AW'($urandom), $urandom, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
